sub_arbiter: RTL

SUB_ARBITER -- requirements
Module: sub_arbiter

---
 rtl/sub_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sub_arbiter (with package parameters_pkg)
//  Description : Round-robin arbiter that shares one external subtraction
//                unit between N_REQ requesters. The winner's operands are
//                captured and presented to the unit, and the unit's result is
//                returned to that requester as a one-cycle response pulse.
//                The arbiter itself does no arithmetic.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SIZE           operand width (default parameters_pkg::DATA_WIDTH)
//    N_REQ          number of requesters, 2..8
//    TIMEOUT_CYCLES watchdog limit in WAIT cycles (watchdog build only)
//  Ports
//    clk, rst            clock, asynchronous active-high reset
//    req[N_REQ]          request levels, held until acked
//    a_in, b_in          packed operands, slice i at bit offset i*SIZE
//    ack[N_REQ]          one-hot pulse: request accepted, operands latched
//    rsp_valid[N_REQ]    one-hot pulse: rsp_result belongs to that requester
//    rsp_result[SIZE+1]  last result, held until the next response
//    busy                high whenever the FSM is not IDLE
//    err                 watchdog fault flag (tied 0 without the watchdog)
//    sub_start, sub_a, sub_b     drive the shared subtraction unit
//    sub_result, sub_done        returned by the shared subtraction unit
//  Build option
//    SUB_ARB_TIMEOUT_EN  when defined, adds a WAIT-cycle watchdog and a
//                        sticky FAULT state left only through rst.
// ============================================================================

package parameters_pkg;
    localparam int DATA_WIDTH = 8;
endpackage

module sub_arbiter
    import parameters_pkg::*;
#(
    parameter int SIZE           = DATA_WIDTH,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*SIZE-1:0] a_in,
    input  logic [N_REQ*SIZE-1:0] b_in,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [SIZE:0]         rsp_result,
    output logic                  busy,
    output logic                  err,
    output logic                  sub_start,
    output logic [SIZE-1:0]       sub_a,
    output logic [SIZE-1:0]       sub_b,
    input  logic [SIZE:0]         sub_result,
    input  logic                  sub_done
);

    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Elaboration-time guard on the legal parameter range.
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || SIZE < 1) begin : g_param_check
        $error("sub_arbiter: illegal parameter set");
    end

`ifdef SUB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] wd_cnt_q, wd_cnt_d;
    logic               err_q, err_d;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [c_ptr_w-1:0] ptr_q, ptr_d;
    logic [c_ptr_w-1:0] owner_q, owner_d;
    logic [SIZE-1:0]    sub_a_q, sub_a_d;
    logic [SIZE-1:0]    sub_b_q, sub_b_d;
    logic [SIZE:0]      rsp_result_q, rsp_result_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic               sub_start_q, sub_start_d;
    logic               busy_q, busy_d;

    // Unpacked views of the operand buses.
    logic [SIZE-1:0] a_arr [N_REQ];
    logic [SIZE-1:0] b_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = a_in[gi*SIZE +: SIZE];
        assign b_arr[gi] = b_in[gi*SIZE +: SIZE];
    end

    // ------------------------------------------------------------------
    // Round-robin search: first requester at or above ptr, wrapping.
    // cand carries one spare bit so ptr+k never overflows before wrap.
    // ------------------------------------------------------------------
    logic               win_found;
    logic [c_ptr_w-1:0] win_idx;
    logic [c_ptr_w:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (c_ptr_w+1)'(k);
            if (cand >= (c_ptr_w+1)'(N_REQ)) begin
                cand = cand - (c_ptr_w+1)'(N_REQ);
            end
            if (!win_found && req[cand[c_ptr_w-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[c_ptr_w-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. ack, sub_start and rsp_valid default to 0 so
    // they are single-cycle pulses by construction.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        sub_a_d      = sub_a_q;
        sub_b_d      = sub_b_q;
        rsp_result_d = rsp_result_q;
        ack_d        = '0;
        rsp_valid_d  = '0;
        sub_start_d  = 1'b0;
`ifdef SUB_ARB_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Registering ack/sub_start here makes them visible in
                // exactly the ISSUE cycle.
                if (win_found) begin
                    sub_a_d        = a_arr[win_idx];
                    sub_b_d        = b_arr[win_idx];
                    owner_d        = win_idx;
                    ack_d[win_idx] = 1'b1;
                    sub_start_d    = 1'b1;
                    state_d        = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef SUB_ARB_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end

            S_WAIT: begin
                if (sub_done) begin
                    rsp_result_d         = sub_result;
                    rsp_valid_d[owner_q] = 1'b1;
                    ptr_d   = (owner_q == c_ptr_w'(N_REQ - 1)) ? '0
                                                               : owner_q + c_ptr_w'(1);
                    state_d = S_IDLE;
                end
`ifdef SUB_ARB_TIMEOUT_EN
                // wd_cnt holds the number of completed WAIT cycles, so
                // the limit is hit in the TIMEOUT_CYCLES-th WAIT cycle.
                else if (wd_cnt_q == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                    rsp_result_d         = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = S_FAULT;
                end else begin
                    wd_cnt_d = wd_cnt_q + c_cnt_w'(1);
                end
`endif
            end

`ifdef SUB_ARB_TIMEOUT_EN
            S_FAULT: begin
                state_d = S_FAULT;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
`ifdef SUB_ARB_TIMEOUT_EN
        err_d  = (state_d == S_FAULT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            sub_a_q      <= '0;
            sub_b_q      <= '0;
            rsp_result_q <= '0;
            ack_q        <= '0;
            rsp_valid_q  <= '0;
            sub_start_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SUB_ARB_TIMEOUT_EN
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            sub_a_q      <= sub_a_d;
            sub_b_q      <= sub_b_d;
            rsp_result_q <= rsp_result_d;
            ack_q        <= ack_d;
            rsp_valid_q  <= rsp_valid_d;
            sub_start_q  <= sub_start_d;
            busy_q       <= busy_d;
`ifdef SUB_ARB_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign sub_start  = sub_start_q;
    assign sub_a      = sub_a_q;
    assign sub_b      = sub_b_q;
    assign busy       = busy_q;
`ifdef SUB_ARB_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

`default_nettype wire
